// File: rtl/i2c_sample_reader.sv
// Open-drain I2C master: one 16-bit ADC read per start (pointer write, repeated START, two-byte read).
// Takes 192*CLK_DIV clocks per read; start is dropped while busy and in the cycle busy falls.
module i2c_sample_reader #(
  parameter int          CLK_DIV  = 250,
  parameter logic [6:0]  DEV_ADDR = 7'h48,
  parameter logic [7:0]  REG_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sda_i,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic        busy,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        ack_err
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, SEND_BYTE, GET_ACK, RSTART, RECV_BYTE, SEND_ACK, STOP
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_idx;   // 0 addr+W, 1 reg, 2 addr+R, 3/4 received bytes
  logic          rx_bit;
  logic          failed;
  logic [15:0]   rx;
  logic [7:0]    tx_byte;
  logic          q_end, bit_end, samp_pt;

  assign q_end   = (div_cnt == DIV_LAST);
  assign bit_end = q_end && (q == 2'd3);
  assign samp_pt = q_end && (q == 2'd2);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start && !sample_valid && !ack_err) state_nxt = START;
      START,
      RSTART:     if (bit_end) state_nxt = SEND_BYTE;
      SEND_BYTE:  if (bit_end && bit_cnt == 3'd7) state_nxt = GET_ACK;
      GET_ACK: begin
        if (bit_end) begin
          if (rx_bit)                  state_nxt = STOP;
          else if (byte_idx == 3'd1)   state_nxt = RSTART;
          else if (byte_idx == 3'd2)   state_nxt = RECV_BYTE;
          else                         state_nxt = SEND_BYTE;
        end
      end
      RECV_BYTE:  if (bit_end && bit_cnt == 3'd7) state_nxt = SEND_ACK;
      SEND_ACK:   if (bit_end) state_nxt = (byte_idx == 3'd3) ? RECV_BYTE : STOP;
      STOP:       if (bit_end) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_byte = {DEV_ADDR, 1'b1};
    if (byte_idx == 3'd0) tx_byte = {DEV_ADDR, 1'b0};
    else if (byte_idx == 3'd1) tx_byte = REG_ADDR;
  end

  // Pin waveform is a pure decode of state and quarter; SDA moves only when Q0 begins.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      START, RSTART: begin
        case (q)
          2'd0:    scl_oe = (state == RSTART);
          2'd2:    sda_oe = 1'b1;
          2'd3:    begin scl_oe = 1'b1; sda_oe = 1'b1; end
          default: ;
        endcase
      end
      SEND_BYTE: begin
        scl_oe = !q[1];
        sda_oe = !tx_byte[3'd7 - bit_cnt];
      end
      GET_ACK, RECV_BYTE: scl_oe = !q[1];
      SEND_ACK: begin
        scl_oe = !q[1];
        sda_oe = (byte_idx == 3'd3);
      end
      STOP: begin
        scl_oe = (q == 2'd0);
        sda_oe = (q != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      q            <= 2'd0;
      bit_cnt      <= 3'd0;
      byte_idx     <= 3'd0;
      rx_bit       <= 1'b0;
      failed       <= 1'b0;
      rx           <= 16'h0000;
      busy         <= 1'b0;
      sample       <= 16'h0000;
      sample_valid <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      sample_valid <= 1'b0;
      ack_err      <= 1'b0;
      if (state == IDLE) begin
        div_cnt  <= '0;
        q        <= 2'd0;
        bit_cnt  <= 3'd0;
        byte_idx <= 3'd0;
        failed   <= 1'b0;
        if (state_nxt == START) begin
          busy <= 1'b1;
          rx   <= 16'h0000;
        end
      end else begin
        div_cnt <= q_end ? '0 : div_cnt + 1'b1;
        if (q_end) q <= q + 2'd1;
        if (samp_pt) begin
          rx_bit <= sda_i;
          if (state == RECV_BYTE) rx <= {rx[14:0], sda_i};
        end
        if (bit_end) begin
          if (state == SEND_BYTE || state == RECV_BYTE) bit_cnt <= bit_cnt + 3'd1;
          if (state == GET_ACK || state == SEND_ACK) byte_idx <= byte_idx + 3'd1;
          if (state == GET_ACK && rx_bit) failed <= 1'b1;
          if (state == STOP) begin
            busy <= 1'b0;
            if (failed) begin
              ack_err <= 1'b1;
            end else begin
              sample       <= rx;
              sample_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/i2c_sample_reader.md
Name: i2c_sample_reader

Overview:
- I2C master that reads one 16-bit audio sample from the external I2C ADC on each trigger and hands it to the recognition core inside top_ssr.
- Sits directly on the board-level scl/sda pins.
- Pins are driven open-drain: top_ssr ties each pin low when the matching *_oe output is 1 and releases it to the pull-up otherwise.
- Transaction: START, addr+W, register pointer, repeated START, addr+R, read MSB, read LSB, STOP.

Parameters:
- CLK_DIV, 250, system clocks per SCL quarter-period (100 MHz / (4*250) = 100 kHz SCL).
- DEV_ADDR, 7'h48, 7-bit I2C address of the ADC.
- REG_ADDR, 8'h00, conversion-result register pointer.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request for one sample read; ignored while busy=1.
- sda_i  in  1  synchronised level of the sda pin.
- scl_oe  out  1  1 = pull SCL low.
- sda_oe  out  1  1 = pull SDA low.
- busy  out  1  high from the cycle after an accepted start until STOP completes.
- sample  out  16  last successfully read sample, MSB first on the bus.
- sample_valid  out  1  one-cycle pulse when sample is updated.
- ack_err  out  1  one-cycle pulse when the slave NACKs any address or register byte.

Behaviour:
- Reset (asynchronous, immediate):
  - scl_oe=0, sda_oe=0, busy=0, sample=16'h0000, sample_valid=0, ack_err=0.
  - FSM returns to IDLE and all counters clear.
  - Reset mid-transaction releases both lines at once; no STOP is generated.
- Timing base: a quarter counter ticks every CLK_DIV clocks and 4 quarters make one bit period Q0..Q3.
  - SCL is low in Q0 and Q1 (scl_oe=1) and released in Q2 and Q3.
  - SDA may change only at the start of Q0.
  - sda_i is sampled on the last clk of Q2.
- FSM states: IDLE, START, SEND_BYTE, GET_ACK, RSTART, RECV_BYTE, SEND_ACK, STOP.
  - IDLE: both lines released. start=1 moves to START in the next cycle and asserts busy.
  - START (4 quarters): Q0–Q1 SDA and SCL released; Q2 SDA low with SCL high; Q3 SCL low.
  - SEND_BYTE: 8 bits, MSB first. Drive sda_oe = ~bit.
  - GET_ACK: SDA released. sda_i=0 at the sample point means ACK.
    - On NACK: go to STOP, pulse ack_err on the cycle STOP completes, no sample_valid.
  - Byte order: {DEV_ADDR,0}, REG_ADDR, then RSTART, then {DEV_ADDR,1}.
  - RSTART: same waveform as START, entered with SCL low.
  - RECV_BYTE: SDA released, 8 bits shifted in MSB first.
  - SEND_ACK: first received byte gets master ACK (sda_oe=1); second gets NACK (sda_oe=0).
  - STOP: Q0 SDA low, SCL low; Q1–Q2 SCL released, SDA low; Q3 SDA released.
    - Then return to IDLE and drop busy.
- sample_valid:
  - On a successful read, sample is loaded and sample_valid pulses in the same cycle that busy falls.
  - sample holds its value until the next successful read; a failed read leaves sample unchanged.
- Clock stretching is not supported; the master ignores SCL readback.
- Duration of a successful transaction:
  - 2 start conditions + 45 data/ack bits + 1 stop = 48 bit periods = 192*CLK_DIV clocks, ±2 cycles for FSM entry/exit.
  - SCL shows exactly 45 rising edges outside start/stop, plus the START/RSTART/STOP high phases.
- start while busy=1 is dropped, not queued. start in the same cycle busy falls is also dropped.
- Simultaneous rst and start: reset wins.

Test Plan:
- CLK_DIV=4, slave model ACKs all bytes and returns 8'hA5 then 8'hC3.
  - Expect sample=16'hA5C3 with a single sample_valid pulse, ack_err never high.
  - Expect busy high for 768±2 clks.
  - Expect decoded bus bytes 8'h90, 8'h00, 8'h91.
- Same setup, slave NACKs the first address byte.
  - Expect a STOP right after the 9th SCL rising edge and an ack_err pulse.
  - Expect sample keeps its prior value and no sample_valid pulse.
- Start pulse issued 100 clks into a transaction.
  - Expect it to be ignored: exactly one sample_valid, and SCL edge count still 45.
- Assert rst at clk 300 of a transaction.
  - Expect scl_oe=0, sda_oe=0, busy=0 in the same cycle.
  - Expect a new start after deassertion to run a complete, correct transaction.
- Protocol monitor across 20 back-to-back reads with random slave data.
  - Expect SDA never changes while SCL is released, except on START, RSTART and STOP edges.
  - Expect every sample to match the slave data.
